modulus_controller_reg: RTL and testbench
=========================================

MODULUS_CONTROLLER_REG -- requirements
Module: modulus_controller

Interface
REQ-001 Port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 Port rst_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk edge.
REQ-003 Port b, input, 1 bit: counter stage B state bit.
REQ-004 Port c, input, 1 bit: counter stage C state bit (true polarity).
REQ-005 Port d, input, 1 bit: counter stage D state bit (true polarity).
REQ-006 Port c_bar, input, 1 bit: counter stage C complement output.
REQ-007 Port d_bar, input, 1 bit: counter stage D complement output.
REQ-008 Port select_in, input, 1 bit: division mode select; 1 = divide-by-240, 0 = divide-by-248.
REQ-009 Port mc, output, 1 bit: modulus control to the dual-modulus prescaler; 1 = assert modulus control.
REQ-010 No parameters; all ports scalar.

Function
REQ-011 Next-state term mc_next = b OR (c_bar AND d_bar) OR (select_in AND c AND d).
REQ-012 mc is a register loaded with mc_next on every rising clk edge while rst_n = 1; latency input->mc exactly 1 clk cycle.
REQ-013 c_bar and d_bar are used as supplied inputs; no internal inversion of c/d and no consistency check between c and c_bar or d and d_bar.
REQ-014 b = 1 forces mc_next = 1 regardless of every other input, in both modes.
REQ-015 c_bar = d_bar = 1 forces mc_next = 1 in both modes.
REQ-016 c = d = 1 with b = 0, c_bar = d_bar = 0: mc_next = 1 when select_in = 1 (240 mode), 0 when select_in = 0 (248 mode).
REQ-017 Any other input combination with b = 0 and (c_bar AND d_bar) = 0 and (c AND d) = 0: mc_next = 0 in both modes.
REQ-018 select_in changes take effect on the next rising edge like any other input; no mode-change handshake, no glitch filtering.
REQ-019 mc is glitch-free: driven solely from the flop output, no combinational path from inputs to mc.
REQ-020 No other internal state; behaviour per cycle depends only on inputs sampled at that edge.

Reset
REQ-021 When rst_n = 0 at a rising clk edge, mc SHALL be 0 after that edge, overriding mc_next.
REQ-022 Reset has priority over all inputs; asserting rst_n = 0 mid-operation clears mc at the next edge.
REQ-023 First edge with rst_n = 1 loads mc_next; mc value before the first clock edge is don't-care.

Verification
REQ-024 rst_n = 0 for 2 cycles, b = 1, select_in = 1 -> mc = 0 throughout reset; release rst_n -> mc = 1 one cycle later.
REQ-025 select_in = 1: apply {b,c,d,c_bar,d_bar} = 10000, then 00011, then 01100, one cycle each -> mc = 1, 1, 1, each one cycle after its input.
REQ-026 select_in = 0: apply 10000, then 00011, then 01100 -> mc = 1, 1, 0, each one cycle after its input.
REQ-027 select_in = 0 and 1: apply 00000 and 01001 -> mc = 0 in both modes.
REQ-028 Hold 01100, toggle select_in 1->0->1 on consecutive cycles -> mc = 1, 0, 1, delayed by one cycle.
REQ-029 Exhaustive sweep of all 64 input combinations after reset -> mc matches REQ-011 one cycle later; assert rst_n = 0 mid-sweep -> mc = 0 on the next edge.

Source files
------------

// File: rtl/modulus_controller_reg_if.sv
// Bundle of counter-stage state bits, mode select and the registered
// modulus-control output shared between the counter side and the controller.
interface modulus_controller_reg_if;
  logic b;          // counter stage B state bit
  logic c;          // counter stage C, true polarity
  logic d;          // counter stage D, true polarity
  logic c_bar;      // counter stage C complement, as supplied by the counter
  logic d_bar;      // counter stage D complement, as supplied by the counter
  logic select_in;  // 1 = divide-by-240, 0 = divide-by-248
  logic mc;         // modulus control to the dual-modulus prescaler

  // Counter / stimulus side: drives the state bits, observes mc
  modport master (
    output b, c, d, c_bar, d_bar, select_in,
    input  mc
  );

  // Controller side: consumes the state bits, drives mc
  modport slave (
    input  b, c, d, c_bar, d_bar, select_in,
    output mc
  );
endinterface

// File: rtl/modulus_controller_reg.sv
// Modulus controller for a 240/248 programmable divider. Decodes the counter
// state into the prescaler modulus-control bit and registers it, so mc is
// driven straight from a flop and never glitches on counter transitions.
module modulus_controller_reg (
  input  logic                         clk,
  input  logic                         rst_n,
  modulus_controller_reg_if.slave      bus
);

  logic w_mc_next;
  logic r_mc;

  // Decode: B forces control, both complements high force control, and the
  // C&D term only counts in 240 mode. Complements are taken as supplied,
  // not derived from c/d, so a mis-wired counter is not masked here.
  always_comb begin
    w_mc_next = bus.b
              | (bus.c_bar & bus.d_bar)
              | (bus.select_in & bus.c & bus.d);
  end

  // Output register with synchronous active-low clear taking priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mc <= 1'b0;
    end else begin
      r_mc <= w_mc_next;
    end
  end

  assign bus.mc = r_mc;

endmodule

// File: tb/tb_modulus_controller_reg.sv
// Self-checking bench for modulus_controller_reg: directed sequences with
// literal expectations plus exhaustive and random sweeps checked every cycle
// against a rule-based model of the controller.
module tb_modulus_controller_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  modulus_controller_reg_if bus ();

  modulus_controller_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule-based reference: walk the decode rules in priority order
  function automatic logic model_mc(input logic [4:0] v, input logic sel);
    logic b, c, d, cb, db;
    {b, c, d, cb, db} = v;
    if (b)             return 1'b1;   // B forces control in both modes
    if (cb && db)      return 1'b1;   // both complements high
    if (c && d)        return sel;    // only in 240 mode
    return 1'b0;
  endfunction

  // Model state: expected mc after each edge, valid once an edge has occurred
  logic exp_mc;
  logic exp_valid;
  initial exp_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) exp_mc = 1'b0;
    else exp_mc = model_mc({bus.b, bus.c, bus.d, bus.c_bar, bus.d_bar}, bus.select_in);
    exp_valid = 1'b1;
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (bus.mc !== exp_mc) begin
        errors++;
        $display("FAIL model_cmp t=%0t mc=%0b expected %0b", $time, bus.mc, exp_mc);
      end
    end
  end

  // Drive one cycle of inputs, then optionally check mc against a literal
  task automatic step(input logic [4:0] v, input logic sel, input logic rn,
                      input logic chk, input logic e, input string nm);
    {bus.b, bus.c, bus.d, bus.c_bar, bus.d_bar} = v;
    bus.select_in = sel;
    rst_n = rn;
    @(posedge clk);
    #3;
    if (chk) begin
      checks++;
      if (bus.mc !== e) begin
        errors++;
        $display("FAIL %s mc=%0b expected %0b", nm, bus.mc, e);
      end else begin
        $display("step %s in=%05b sel=%0b rst_n=%0b mc=%0b", nm, v, sel, rn, bus.mc);
      end
    end
  endtask

  initial begin
    logic [5:0] combo;
    logic [4:0] rv;
    checks = 0;
    errors = 0;
    {bus.b, bus.c, bus.d, bus.c_bar, bus.d_bar} = 5'b10000;
    bus.select_in = 1'b1;
    rst_n = 1'b0;

    // Reset held two cycles with b=1: mc stays 0, then 1 one cycle after release
    step(5'b10000, 1'b1, 1'b0, 1'b1, 1'b0, "rst_hold0");
    step(5'b10000, 1'b1, 1'b0, 1'b1, 1'b0, "rst_hold1");
    step(5'b10000, 1'b1, 1'b1, 1'b1, 1'b1, "rst_release");

    // 240 mode
    step(5'b10000, 1'b1, 1'b1, 1'b1, 1'b1, "m240_b");
    step(5'b00011, 1'b1, 1'b1, 1'b1, 1'b1, "m240_cdbar");
    step(5'b01100, 1'b1, 1'b1, 1'b1, 1'b1, "m240_cd");
    // 248 mode
    step(5'b10000, 1'b0, 1'b1, 1'b1, 1'b1, "m248_b");
    step(5'b00011, 1'b0, 1'b1, 1'b1, 1'b1, "m248_cdbar");
    step(5'b01100, 1'b0, 1'b1, 1'b1, 1'b0, "m248_cd");
    // Inactive combinations in both modes
    step(5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, "zero_248");
    step(5'b01001, 1'b0, 1'b1, 1'b1, 1'b0, "mixed_248");
    step(5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, "zero_240");
    step(5'b01001, 1'b1, 1'b1, 1'b1, 1'b0, "mixed_240");
    // Hold C=D=1 and toggle the mode each cycle
    step(5'b01100, 1'b1, 1'b1, 1'b1, 1'b1, "tog_240a");
    step(5'b01100, 1'b0, 1'b1, 1'b1, 1'b0, "tog_248");
    step(5'b01100, 1'b1, 1'b1, 1'b1, 1'b1, "tog_240b");

    // Exhaustive sweep of {select_in,b,c,d,c_bar,d_bar}; reset mid-sweep
    for (int i = 0; i < 64; i++) begin
      combo = 6'(i);
      step(combo[4:0], combo[5], 1'b1, 1'b0, 1'b0, "sweep");
      if (i == 40) step(5'b10011, 1'b1, 1'b0, 1'b1, 1'b0, "sweep_rst");
    end

    // Random stimulus with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      rv = 5'($urandom);
      step(rv, 1'($urandom), ($urandom_range(0, 19) != 0), 1'b0, 1'b0, "rand");
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
